fadd_align: RTL and testbench

FADD_ALIGN -- requirements
Module: fadd_align

---
 rtl/fadd_align.sv | 197 +++++++++++++++++++
 tb/tb_fadd_align.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fadd_align.sv
// Two-stage operand alignment front end for a single-precision adder.
// Optional special-value flags are built only when FADD_SPECIAL_EN is defined.
module fadd_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic        out_sub,
    output logic [7:0]  out_exp,
    output logic [26:0] out_mant_l,
    output logic [26:0] out_mant_s,
    output logic        out_nan,
    output logic        out_inf
);

    // Magnitude key {effective exp, hidden, frac}; denormals take exponent 1.
    function automatic logic [31:0] unpack_mag(input logic [31:0] f);
        if (f[30:23] == 8'd0) begin
            unpack_mag = {8'd1, 1'b0, f[22:0]};
        end else begin
            unpack_mag = {f[30:23], 1'b1, f[22:0]};
        end
    endfunction

    // Right shift with every lost bit folded into bit 0.
    function automatic logic [26:0] align_shift(input logic [23:0] m, input logic [7:0] d);
        logic [53:0] ext;
        ext = {m, 3'b000, 27'd0} >> d;
        if (d >= 8'd27) begin
            align_shift = {26'd0, |m};
        end else begin
            align_shift = {ext[53:28], ext[27] | (|ext[26:0])};
        end
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic        s1_sub_q, s1_sub_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [26:0] s1_mant_l_q, s1_mant_l_d;
    logic [23:0] s1_mant_s_q, s1_mant_s_d;
    logic [7:0]  s1_diff_q, s1_diff_d;
    logic        s1_nan_q, s1_nan_d;
    logic        s1_inf_q, s1_inf_d;

    logic        s2_valid_q, s2_valid_d;
    logic        s2_sign_q, s2_sign_d;
    logic        s2_sub_q, s2_sub_d;
    logic [7:0]  s2_exp_q, s2_exp_d;
    logic [26:0] s2_mant_l_q, s2_mant_l_d;
    logic [26:0] s2_mant_s_q, s2_mant_s_d;
    logic        s2_nan_q, s2_nan_d;
    logic        s2_inf_q, s2_inf_d;

    logic        s2_adv_s;
    logic        accept_s;
    logic [31:0] mag_a_s, mag_b_s, mag_l_s, mag_s_s;
    logic        a_big_s;
    logic        nan_s, inf_s;

    assign s2_adv_s = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv_s;
    assign accept_s = in_valid && in_ready;

    assign mag_a_s = unpack_mag(in_a);
    assign mag_b_s = unpack_mag(in_b);
    assign a_big_s = (mag_a_s >= mag_b_s);
    assign mag_l_s = a_big_s ? mag_a_s : mag_b_s;
    assign mag_s_s = a_big_s ? mag_b_s : mag_a_s;

`ifdef FADD_SPECIAL_EN
    logic a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    assign a_nan_s = (&in_a[30:23]) && (|in_a[22:0]);
    assign b_nan_s = (&in_b[30:23]) && (|in_b[22:0]);
    assign a_inf_s = (&in_a[30:23]) && !(|in_a[22:0]);
    assign b_inf_s = (&in_b[30:23]) && !(|in_b[22:0]);
    assign nan_s   = a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (in_a[31] != in_b[31]));
    assign inf_s   = (a_inf_s || b_inf_s) && !nan_s;
`else
    assign nan_s = 1'b0;
    assign inf_s = 1'b0;
`endif

    // Stage 1 next state: unpack and swap on accept, otherwise hold or drain.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_sub_d    = s1_sub_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_l_d = s1_mant_l_q;
        s1_mant_s_d = s1_mant_s_q;
        s1_diff_d   = s1_diff_q;
        s1_nan_d    = s1_nan_q;
        s1_inf_d    = s1_inf_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (accept_s) begin
            s1_sign_d   = a_big_s ? in_a[31] : in_b[31];
            s1_sub_d    = in_a[31] ^ in_b[31];
            s1_exp_d    = mag_l_s[31:24];
            s1_mant_l_d = {mag_l_s[23:0], 3'b000};
            s1_mant_s_d = mag_s_s[23:0];
            s1_diff_d   = mag_l_s[31:24] - mag_s_s[31:24];
            s1_nan_d    = nan_s;
            s1_inf_d    = inf_s;
        end else begin
            s1_diff_d   = s1_diff_q;
        end
    end

    // Stage 2 next state: shift the smaller mantissa whenever the stage advances.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_sub_d    = s2_sub_q;
        s2_exp_d    = s2_exp_q;
        s2_mant_l_d = s2_mant_l_q;
        s2_mant_s_d = s2_mant_s_q;
        s2_nan_d    = s2_nan_q;
        s2_inf_d    = s2_inf_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s2_adv_s && s1_valid_q) begin
            s2_sign_d   = s1_sign_q;
            s2_sub_d    = s1_sub_q;
            s2_exp_d    = s1_exp_q;
            s2_mant_l_d = s1_mant_l_q;
            s2_mant_s_d = align_shift(s1_mant_s_q, s1_diff_q);
            s2_nan_d    = s1_nan_q;
            s2_inf_d    = s1_inf_q;
        end else begin
            s2_mant_s_d = s2_mant_s_q;
        end
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_exp_q    <= 8'd0;
            s1_mant_l_q <= 27'd0;
            s1_mant_s_q <= 24'd0;
            s1_diff_q   <= 8'd0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_sub_q    <= 1'b0;
            s2_exp_q    <= 8'd0;
            s2_mant_l_q <= 27'd0;
            s2_mant_s_q <= 27'd0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_sub_q    <= s1_sub_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_l_q <= s1_mant_l_d;
            s1_mant_s_q <= s1_mant_s_d;
            s1_diff_q   <= s1_diff_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_sub_q    <= s2_sub_d;
            s2_exp_q    <= s2_exp_d;
            s2_mant_l_q <= s2_mant_l_d;
            s2_mant_s_q <= s2_mant_s_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= s2_inf_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sign   = s2_sign_q;
    assign out_sub    = s2_sub_q;
    assign out_exp    = s2_exp_q;
    assign out_mant_l = s2_mant_l_q;
    assign out_mant_s = s2_mant_s_q;
    assign out_nan    = s2_nan_q;
    assign out_inf    = s2_inf_q;

endmodule

// File: tb/tb_fadd_align.sv
// Directed self-checking bench for fadd_align with hand-computed alignment results.
module tb_fadd_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign, out_sub, out_nan, out_inf;
    logic [7:0]  out_exp;
    logic [26:0] out_mant_l, out_mant_s;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_nan;

    fadd_align dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_sub(out_sub), .out_exp(out_exp),
        .out_mant_l(out_mant_l), .out_mant_s(out_mant_s),
        .out_nan(out_nan), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic sg, input logic sb, input logic [7:0] e,
                           input logic [26:0] ml, input logic [26:0] ms, input logic nn, input logic nf);
        chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
        chk({tag, ".sign"},   {31'd0, out_sign},  {31'd0, sg});
        chk({tag, ".sub"},    {31'd0, out_sub},   {31'd0, sb});
        chk({tag, ".exp"},    {24'd0, out_exp},   {24'd0, e});
        chk({tag, ".mant_l"}, {5'd0, out_mant_l}, {5'd0, ml});
        chk({tag, ".mant_s"}, {5'd0, out_mant_s}, {5'd0, ms});
        chk({tag, ".nan"},    {31'd0, out_nan},   {31'd0, nn});
        chk({tag, ".inf"},    {31'd0, out_inf},   {31'd0, nf});
    endtask

    // One isolated transaction: exact 2-edge latency, then no duplicate.
    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic sb, input logic [7:0] e,
                        input logic [26:0] ml, input logic [26:0] ms, input logic nn, input logic nf);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_a = a; in_b = b;
        step();
        in_valid = 1'b0;
        chk({tag, ".early"}, {31'd0, out_valid}, 32'd0);
        step();
        chk_res(tag, sg, sb, e, ml, ms, nn, nf);
        step();
        chk({tag, ".nodup"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
`ifdef FADD_SPECIAL_EN
        exp_nan = 1'b1;
`else
        exp_nan = 1'b0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
        step(); step();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.exp", {24'd0, out_exp}, 32'd0);
        chk("rst.mant_l", {5'd0, out_mant_l}, 32'd0);
        chk("rst.mant_s", {5'd0, out_mant_s}, 32'd0);
        chk("rst.flags", {28'd0, out_sign, out_sub, out_nan, out_inf}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel.valid", {31'd0, out_valid}, 32'd0);
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

        run1("one_two",  32'h3F800000, 32'h40000000, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
        run1("diff24",   32'h3F800000, 32'h33800000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000004, 1'b0, 1'b0);
        run1("diff30",   32'h3F800000, 32'h30800001, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0);
        run1("neg_pos",  32'hBF800000, 32'h3F800000, 1'b1, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0);
        run1("b_larger", 32'h40400000, 32'hC1200000, 1'b1, 1'b1, 8'h82, 27'h5000000, 27'h1800000, 1'b0, 1'b0);
        run1("sticky5",  32'h3F800000, 32'h3D000001, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0200001, 1'b0, 1'b0);
        run1("diff26",   32'h3F800000, 32'h32800000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0);
        run1("diff27",   32'h3F800000, 32'h32000000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0);
        run1("zero_s",   32'h3F800000, 32'h00000000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000000, 1'b0, 1'b0);
        run1("denorm",   32'h00000001, 32'h00000000, 1'b0, 1'b0, 8'h01, 27'h0000008, 27'h0000000, 1'b0, 1'b0);
        run1("inf_inf",  32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 8'hFF, 27'h4000000, 27'h4000000, exp_nan, 1'b0);

        // Back-pressure: three pairs with the consumer stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        step();
        in_a = 32'h3F800000; in_b = 32'h33800000;
        chk("bp.rdy2", {31'd0, in_ready}, 32'd1);
        step();
        in_a = 32'hBF800000; in_b = 32'h3F800000;
        chk("bp.full", {31'd0, in_ready}, 32'd0);
        chk_res("bp.p1", 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
        step();
        chk("bp.full2", {31'd0, in_ready}, 32'd0);
        chk_res("bp.p1hold", 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
        step();
        chk_res("bp.p1hold2", 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp.rdy3", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk_res("bp.p2", 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000004, 1'b0, 1'b0);
        step();
        chk_res("bp.p3", 1'b1, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0);
        step();
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        // Reset asserted with both stages occupied.
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        step();
        in_a = 32'h40400000; in_b = 32'hC1200000;
        step();
        in_valid = 1'b0;
        chk("mid.valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.async", {31'd0, out_valid}, 32'd0);
        chk("mid.exp", {24'd0, out_exp}, 32'd0);
        step();
        chk("mid.edge", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid.stale1", {31'd0, out_valid}, 32'd0);
        step();
        chk("mid.stale2", {31'd0, out_valid}, 32'd0);
        run1("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
